// File: rtl/reg_share_arb_pkg.sv
// Shared types and constants for the round-robin register-sharing arbiter.
package reg_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned DW_DEF    = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick
    import reg_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        win_oh,
    output logic [idx_w(N_REQ)-1:0] win_idx,
    output logic                    any_valid
);

    localparam int unsigned IW = idx_w(N_REQ);

    // Scan [ptr, N_REQ) first, then wrap to [0, ptr).
    always_comb begin
        win_oh    = '0;
        win_idx   = '0;
        any_valid = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_valid && req[i] && (i >= 32'(ptr))) begin
                any_valid  = 1'b1;
                win_idx    = IW'(i);
                win_oh[i]  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_valid && req[i] && (i < 32'(ptr))) begin
                any_valid  = 1'b1;
                win_idx    = IW'(i);
                win_oh[i]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter owning one shared DW-bit register written by N_REQ requesters.
module reg_share_arb
    import reg_share_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DW-1:0]     wdata,
    input  logic                    clr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DW-1:0]           q,
    output logic [idx_w(N_REQ)-1:0] owner,
    output logic                    busy
);

    localparam int unsigned IW = idx_w(N_REQ);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DW-1:0]     q_q, q_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;

    logic [N_REQ-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [DW-1:0]     sel_data;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req       (req),
        .ptr       (ptr_q),
        .win_oh    (pick_oh),
        .win_idx   (pick_idx),
        .any_valid (pick_any)
    );

    // Select the current owner's write data lane.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IW'(i)) begin
                sel_data = wdata[i*DW +: DW];
            end
        end
    end

    // Next-state and output logic; clr always zeroes the shared register and wins over a commit.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;

        if (clr) begin
            q_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (!clr && pick_any) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = IDLE;
                if (!clr && req[owner_q]) begin
                    q_d            = sel_data;
                    ack_d[owner_q] = 1'b1;
                    ptr_d          = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter that shares one DW-bit D-flip-flop data register among N_REQ requesters. Each requester raises a request with write data; the block grants one requester at a time, commits its data into the shared register, and acknowledges it. It sits between the requester logic and the shared register, which it owns and exposes as `q`. The grant/commit/ack sequence is an explicit three-state FSM.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DW`, 8, data width of the shared register
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  N_REQ  per-requester request level; held until ack or withdrawn
- `wdata`  in  N_REQ*DW  requester i data at bits [i*DW +: DW]
- `clr`  in  1  synchronous clear of shared register, aborts in-flight transaction
- `gnt`  out  N_REQ  one-hot grant, registered
- `ack`  out  N_REQ  one-hot single-cycle commit acknowledge, registered
- `q`  out  DW  shared register value
- `owner`  out  clog2(N_REQ)  index of last granted requester
- `busy`  out  1  high whenever FSM not in IDLE

## Operation
- States: IDLE, GRANT, DONE.
- IDLE: if `clr` -> stay IDLE. Else if `req` != 0 -> pick winner w = first set bit scanning from `ptr` upward with wrap; next edge: `gnt` <= onehot(w), `owner` <= w, state <= GRANT. `req` == 0 -> stay.
- GRANT: if `clr` -> `q` <= 0, `gnt` <= 0, no ack, `ptr` unchanged, state <= IDLE. Else if `req[owner]` still high -> `q` <= `wdata[owner]`, `ack` <= onehot(owner), `gnt` <= 0, `ptr` <= (owner+1) mod N_REQ, state <= DONE. Else (withdrawn) -> `gnt` <= 0, no write, no ack, `ptr` unchanged, state <= IDLE.
- DONE: `ack` <= 0, state <= IDLE unconditionally; `clr` here only clears `q`.
- `clr` in any state: `q` <= 0 on next edge; `clr` beats a same-cycle commit.
- Requests from non-granted requesters are ignored until next IDLE arbitration; no queuing.
- Fairness: a requester holding `req` is served within N_REQ transactions.

## Timing
- Reset values: `q` = 0, `gnt` = 0, `ack` = 0, `owner` = 0, `busy` = 0, `ptr` = 0, state = IDLE.
- Request sampled in IDLE at edge t -> `gnt` high cycle t+1 -> `q` updated and `ack` high cycle t+2 -> `ack` low and FSM in IDLE cycle t+3; next arbitration sampled at edge ending t+3.
- Throughput: one write per 3 cycles.
- `wdata[owner]` sampled at the GRANT-exit edge only; requester must hold it valid while `gnt` is high.
- `gnt` and `ack` never high in the same cycle; at most one bit of each set.
- `busy` = registered (state != IDLE), high in GRANT and DONE cycles.
- Async reset mid-transaction: all outputs to reset values immediately; no partial commit.

## Structure
- Package `reg_share_arb_pkg`: state enum (IDLE, GRANT, DONE), default N_REQ/DW constants, owner-index width function.
- Sub-module `rr_pick`: combinational round-robin picker (inputs `req`, `ptr`; outputs one-hot winner, index, any-valid). Everything else, including the shared register, lives in the top level.

## Test plan
- Single request: `req`=0001, `wdata[0]`=8'hA5 -> `gnt`=0001 at t+1, `q`=8'hA5 and `ack`=0001 at t+2, `busy` low at t+3.
- All four requesting continuously, data 8'h10..8'h13 -> grants in order 0,1,2,3,0; `q` sequence 10,11,12,13,10; one commit per 3 cycles.
- Request withdrawn in GRANT cycle -> no ack, `q` unchanged, `ptr` unchanged; same requester wins next arbitration.
- `clr` asserted in GRANT cycle with `wdata`=8'hFF -> `q`=0, no ack, FSM back to IDLE next cycle.
- `rst_n` pulsed low during GRANT with `q`=8'h3C -> `q`, `gnt`, `ack`, `busy` go 0 immediately; after release, `req`=0100 is granted first with `ptr`=0 scan order.
